// File: rtl/i2c_master_fsm.sv
// Single-byte I2C master: START, 7-bit address + R/W, ACK check, one data byte, STOP.
// Pad enables are registered, so SCL/SDA never glitch while the state vector changes.
module i2c_master_fsm #(
   parameter int CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       soft_reset,
   input  logic       start,
   input  logic       readwrite,
   input  logic [6:0] slave_addr,
   input  logic [7:0] write_data,
   input  logic       sda_i,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic [7:0] read_data,
   output logic       busy,
   output logic       done,
   output logic       ack_error
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WRITE,
      WRITE_ACK,
      READ,
      READ_NACK,
      STOP,
      DONE
   } state_t;

   state_t           state, state_n;
   logic [1:0]       phase, phase_n;
   logic [2:0]       bit_cnt, bit_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             start_q, start_q_n;
   logic [7:0]       addr_byte, addr_byte_n;
   logic [7:0]       wdata_q, wdata_n;
   logic [7:0]       rx_q, rx_n;
   logic [7:0]       read_data_n;
   logic             ack_error_n;
   logic             busy_n;
   logic             done_n;
   logic             scl_n, sda_n;
   logic             tick;
   logic             trigger;

   // Pad enables for a given position in the transaction; 1 pulls the line low.
   function automatic logic [1:0] pad_decode(input state_t     s,
                                             input logic [1:0] p,
                                             input logic [2:0] b,
                                             input logic [7:0] abyte,
                                             input logic [7:0] wbyte);
      logic       bit_scl;
      logic [1:0] pads;
      bit_scl = (p == 2'd0) || (p == 2'd3);
      pads    = 2'b00;
      case (s)
         START:                                pads = {p == 2'd3, p[1]};
         ADDR:                                 pads = {bit_scl, ~abyte[b]};
         WRITE:                                pads = {bit_scl, ~wbyte[b]};
         ADDR_ACK, WRITE_ACK, READ, READ_NACK: pads = {bit_scl, 1'b0};
         STOP:                                 pads = {p == 2'd0, p != 2'd3};
         default:                              pads = 2'b00;
      endcase
      return pads;
   endfunction

   assign tick    = busy && (cnt == CNT_W'(CLK_DIV - 1));
   assign trigger = (state == IDLE) && start && !start_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= 2'd0;
         bit_cnt   <= 3'd7;
         cnt       <= '0;
         start_q   <= 1'b0;
         addr_byte <= 8'h00;
         wdata_q   <= 8'h00;
         rx_q      <= 8'h00;
         read_data <= 8'h00;
         ack_error <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         scl_oe    <= 1'b0;
         sda_oe    <= 1'b0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         bit_cnt   <= bit_n;
         cnt       <= cnt_n;
         start_q   <= start_q_n;
         addr_byte <= addr_byte_n;
         wdata_q   <= wdata_n;
         rx_q      <= rx_n;
         read_data <= read_data_n;
         ack_error <= ack_error_n;
         busy      <= busy_n;
         done      <= done_n;
         scl_oe    <= scl_n;
         sda_oe    <= sda_n;
      end
   end

   // Every bit-level state spends four ticks, one per SCL phase; bit_cnt wraps 0 -> 7
   // on its own, so it is already primed for the next byte.
   always_comb begin
      state_n     = state;
      phase_n     = phase;
      bit_n       = bit_cnt;
      cnt_n       = cnt;
      start_q_n   = start;
      addr_byte_n = addr_byte;
      wdata_n     = wdata_q;
      rx_n        = rx_q;
      read_data_n = read_data;
      ack_error_n = ack_error;
      busy_n      = busy;
      done_n      = 1'b0;

      if (busy) begin
         cnt_n = tick ? '0 : cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            if (trigger) begin
               state_n     = START;
               phase_n     = 2'd0;
               bit_n       = 3'd7;
               cnt_n       = '0;
               addr_byte_n = {slave_addr, readwrite};
               wdata_n     = write_data;
               ack_error_n = 1'b0;
               busy_n      = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            cnt_n   = '0;
         end
         default: begin
            if (tick) begin
               phase_n = phase + 2'd1;
               case (state)
                  START: begin
                     if (phase == 2'd3) state_n = ADDR;
                  end
                  ADDR: begin
                     if (phase == 2'd3) begin
                        bit_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) state_n = ADDR_ACK;
                     end
                  end
                  ADDR_ACK: begin
                     if (phase == 2'd2 && sda_i) ack_error_n = 1'b1;
                     if (phase == 2'd3) begin
                        state_n = ack_error ? STOP : (addr_byte[0] ? READ : WRITE);
                     end
                  end
                  WRITE: begin
                     if (phase == 2'd3) begin
                        bit_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) state_n = WRITE_ACK;
                     end
                  end
                  WRITE_ACK: begin
                     if (phase == 2'd2 && sda_i) ack_error_n = 1'b1;
                     if (phase == 2'd3) state_n = STOP;
                  end
                  READ: begin
                     if (phase == 2'd2) rx_n = {rx_q[6:0], sda_i};
                     if (phase == 2'd3) begin
                        bit_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) state_n = READ_NACK;
                     end
                  end
                  READ_NACK: begin
                     if (phase == 2'd3) begin
                        read_data_n = rx_q;
                        state_n     = STOP;
                     end
                  end
                  STOP: begin
                     if (phase == 2'd3) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                     end
                  end
                  default: state_n = IDLE;
               endcase
            end
         end
      endcase

      // Abort drops the bus on the spot; no STOP is sent.
      if (soft_reset) begin
         state_n     = IDLE;
         phase_n     = 2'd0;
         bit_n       = 3'd7;
         cnt_n       = '0;
         start_q_n   = 1'b0;
         addr_byte_n = 8'h00;
         wdata_n     = 8'h00;
         rx_n        = 8'h00;
         read_data_n = 8'h00;
         ack_error_n = 1'b0;
         busy_n      = 1'b0;
         done_n      = 1'b0;
      end

      {scl_n, sda_n} = pad_decode(state_n, phase_n, bit_n, addr_byte_n, wdata_n);
   end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Directed bench for i2c_master_fsm: a table of single-byte transactions against a
// small open-drain slave model, plus hand sequences for start-edge, abort and reset cases.
module tb_i2c_master_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       soft_reset = 1'b0;
   logic       start = 1'b0;
   logic       readwrite = 1'b0;
   logic [6:0] slave_addr = 7'h00;
   logic [7:0] write_data = 8'h00;
   logic       sda_i;
   logic       scl_oe, sda_oe, busy, done, ack_error;
   logic [7:0] read_data;

   logic       ack_addr = 1'b1;
   logic       ack_data = 1'b1;
   logic       is_read = 1'b0;
   logic [7:0] slave_byte = 8'h00;
   logic       slave_pull;
   logic       scl_line, sda_line;
   logic       scl_prev = 1'b1, sda_prev = 1'b1;
   int         win = 99;
   logic [31:0] cap_bits = '0;
   int         cap_n = 0;
   int         done_count = 0;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  wdata;
      logic        s_ack_addr;
      logic        s_ack_data;
      logic [7:0]  s_byte;
      logic [31:0] exp_bits;
      int          exp_nbits;
      int          exp_lat;
      logic        exp_ae;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t vecs[3];

   i2c_master_fsm #(.CLK_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .soft_reset (soft_reset),
      .start      (start),
      .readwrite  (readwrite),
      .slave_addr (slave_addr),
      .write_data (write_data),
      .sda_i      (sda_i),
      .scl_oe     (scl_oe),
      .sda_oe     (sda_oe),
      .read_data  (read_data),
      .busy       (busy),
      .done       (done),
      .ack_error  (ack_error)
   );

   always #5 clk = ~clk;

   assign scl_line = ~scl_oe;
   assign sda_line = ~(sda_oe | slave_pull);
   assign sda_i    = sda_line;

   // Bit windows counted by SCL falls after a START: 1-8 address, 9 ACK, 10-17 data, 18 ACK.
   always_comb begin
      slave_pull = 1'b0;
      if (win == 9) slave_pull = ack_addr;
      else if (win == 18) slave_pull = ack_data && !is_read;
      else if (is_read && win >= 10 && win <= 17) slave_pull = !slave_byte[3'(17 - win)];
   end

   always @(negedge clk) begin
      if (scl_line && sda_prev && !sda_line) win <= 0;
      else if (scl_prev && !scl_line) win <= win + 1;
      if (!scl_prev && scl_line) begin
         cap_bits <= {cap_bits[30:0], sda_line};
         cap_n    <= cap_n + 1;
      end
      if (done) done_count <= done_count + 1;
      scl_prev <= scl_line;
      sda_prev <= sda_line;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic set_slave(input vec_t v);
      ack_addr   = v.s_ack_addr;
      ack_data   = v.s_ack_data;
      is_read    = v.rw;
      slave_byte = v.s_byte;
      readwrite  = v.rw;
      slave_addr = v.addr;
      write_data = v.wdata;
   endtask

   task automatic wait_busy(input string name);
      int cyc = 0;
      while (!busy && cyc < 100) begin @(negedge clk); cyc++; end
      checkOutput(name, 32'(cyc < 100), 32'd1);
   endtask

   task automatic wait_win(input int target, input string name);
      int cyc = 0;
      while (win != target && cyc < 3000) begin @(negedge clk); cyc++; end
      checkOutput(name, 32'(cyc < 3000), 32'd1);
   endtask

   task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] bits,
                                output int nbits, output logic [7:0] rd, output logic ae,
                                output logic done_after, output logic busy_after);
      int base;
      int cyc;
      set_slave(v);
      start = 1'b0;
      @(negedge clk);
      base  = cap_n;
      start = 1'b1;
      cyc   = 0;
      while (!busy && cyc < 100) begin @(negedge clk); cyc++; end
      lat = 0;
      while (!done && lat < 2000) begin @(negedge clk); lat++; end
      rd = read_data;
      ae = ack_error;
      @(negedge clk);
      done_after = done;
      busy_after = busy;
      start = 1'b0;
      nbits = cap_n - base;
      bits  = (nbits >= 32) ? cap_bits : (cap_bits & ((32'd1 << nbits) - 32'd1));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int          lat, nbits;
      logic [31:0] bits;
      logic [7:0]  rd;
      logic        ae, d_after, b_after;
      applyStimulus(v, lat, bits, nbits, rd, ae, d_after, b_after);
      checkOutput({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      checkOutput({tag, "_nbits"}, 32'(nbits), 32'(v.exp_nbits));
      checkOutput({tag, "_sda_bits"}, bits, v.exp_bits);
      checkOutput({tag, "_ack_error"}, 32'(ae), 32'(v.exp_ae));
      checkOutput({tag, "_read_data"}, 32'(rd), 32'(v.exp_rd));
      checkOutput({tag, "_done_width"}, 32'(d_after), 32'd0);
      checkOutput({tag, "_busy_clear"}, 32'(b_after), 32'd0);
   endtask

   initial begin
      int dc;
      int cyc;

      // write A5 to 50: 1010000_0, ACK, 10100101, ACK, then the STOP SCL pulse (SDA low)
      vecs[0] = '{rw: 1'b0, addr: 7'h50, wdata: 8'hA5, s_ack_addr: 1'b1, s_ack_data: 1'b1,
                  s_byte: 8'h00, exp_bits: 32'b1010000001010010100, exp_nbits: 19,
                  exp_lat: 320, exp_ae: 1'b0, exp_rd: 8'h00};
      // read from 50, slave sends 3C, master NACKs (line high), STOP
      vecs[1] = '{rw: 1'b1, addr: 7'h50, wdata: 8'h00, s_ack_addr: 1'b1, s_ack_data: 1'b0,
                  s_byte: 8'h3C, exp_bits: 32'b1010000100011110010, exp_nbits: 19,
                  exp_lat: 320, exp_ae: 1'b0, exp_rd: 8'h3C};
      // no device: address NACK goes straight to STOP, read_data keeps 3C
      vecs[2] = '{rw: 1'b0, addr: 7'h50, wdata: 8'h77, s_ack_addr: 1'b0, s_ack_data: 1'b0,
                  s_byte: 8'h00, exp_bits: 32'b1010000010, exp_nbits: 10,
                  exp_lat: 176, exp_ae: 1'b1, exp_rd: 8'h3C};

      #12;
      checkOutput("reset_scl_oe", 32'(scl_oe), 32'd0);
      checkOutput("reset_sda_oe", 32'(sda_oe), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_ack_error", 32'(ack_error), 32'd0);
      checkOutput("reset_read_data", 32'(read_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
         repeat (5) @(negedge clk);
      end

      // start held high fires once; a toggle while busy is dropped
      $display("[TB] start-edge sequence");
      set_slave(vecs[0]);
      dc = done_count;
      @(negedge clk);
      start = 1'b1;
      repeat (700) @(negedge clk);
      checkOutput("held_start_once", 32'(done_count - dc), 32'd1);
      checkOutput("held_start_ack_error", 32'(ack_error), 32'd0);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      wait_busy("edge_busy_rise");
      repeat (40) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      repeat (700) @(negedge clk);
      checkOutput("busy_edge_dropped", 32'(done_count - dc), 32'd2);
      checkOutput("write_keeps_read_data", 32'(read_data), 32'h3C);
      start = 1'b0;
      @(negedge clk);

      // asynchronous reset in the middle of a read
      $display("[TB] async reset mid-read");
      set_slave(vecs[1]);
      start = 1'b1;
      wait_busy("rd_busy_rise");
      wait_win(12, "rd_reach_bit5");
      checkOutput("rd_busy_before_rst", 32'(busy), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_pads", 32'({scl_oe, sda_oe}), 32'd0);
      checkOutput("rst_read_data", 32'(read_data), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // soft reset during data bit 3 of a write, then a clean transaction
      $display("[TB] soft reset mid-write");
      set_slave(vecs[0]);
      dc = done_count;
      start = 1'b1;
      wait_busy("wr_busy_rise");
      wait_win(14, "wr_reach_bit3");
      repeat (6) @(negedge clk);
      checkOutput("wr_busy_before_abort", 32'(busy), 32'd1);
      soft_reset = 1'b1;
      start      = 1'b0;
      @(negedge clk);
      checkOutput("abort_scl_oe", 32'(scl_oe), 32'd0);
      checkOutput("abort_sda_oe", 32'(sda_oe), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      soft_reset = 1'b0;
      cyc = 0;
      repeat (400) begin
         @(negedge clk);
         if (busy) cyc++;
      end
      checkOutput("abort_no_done", 32'(done_count - dc), 32'd0);
      checkOutput("abort_stays_idle", 32'(cyc), 32'd0);
      run_vec(vecs[0], "post_abort");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
